// File: rtl/game_regfile_pkg.sv
// Shared widths, tap defaults and clear-sequencer state type for the game register file.
package game_regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int TAP_BASE_DEF = 29;  // blockID register
  localparam int NUM_TAPS_DEF = 3;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: zeroes reg[1..NUM_REGS-1], one per cycle, starting the cycle after clr_req.
// Busy for NUM_REGS-1 cycles; clr_req is ignored while busy.
module rf_clear_seq
  import game_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  clr_state_t        state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            ptr      <= PTR_ONE;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + PTR_ONE;
          // Last register is being zeroed this cycle.
          if (&ptr) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clr_we   = clr_busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/game_regfile.sv
// Register file with CPU + handshaked external write ports, write-to-read bypass, clear engine, tap bus.
// Reads are combinational; ext_ack is held low on a same-address CPU write or while clearing.
module game_regfile
  import game_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int TAP_BASE = TAP_BASE_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF
) (
  input  logic                       clock,
  input  logic                       ctrl_reset_n,
  input  logic                       ctrl_writeEnable,
  input  logic [ADDR_W-1:0]          ctrl_writeReg,
  input  logic [DATA_W-1:0]          data_writeReg,
  input  logic [ADDR_W-1:0]          ctrl_readRegA,
  input  logic [ADDR_W-1:0]          ctrl_readRegB,
  output logic [DATA_W-1:0]          data_readRegA,
  output logic [DATA_W-1:0]          data_readRegB,
  input  logic                       ext_req,
  input  logic [ADDR_W-1:0]          ext_addr,
  input  logic [DATA_W-1:0]          ext_data,
  output logic                       ext_ack,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic [DATA_W*NUM_TAPS-1:0] tap_data
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              cpu_pend;
  logic              cpu_we;
  logic              ext_we;

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clock),
    .rst_n    (ctrl_reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // The CPU owns a contested address; the external requester simply retries next cycle.
  assign cpu_pend = ctrl_writeEnable & ~clr_busy;
  assign cpu_we   = cpu_pend & (ctrl_writeReg != '0);
  assign ext_ack  = ext_req & ~clr_busy &
                    ~(ctrl_writeEnable & (ctrl_writeReg == ext_addr) & (ext_addr != '0));
  assign ext_we   = ext_ack & (ext_addr != '0);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (clr_we) regs[clr_addr] <= '0;
      if (cpu_we) regs[ctrl_writeReg] <= data_writeReg;
      if (ext_we) regs[ext_addr] <= ext_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs[addr];
    if (addr == '0)                                val = '0;
    else if (cpu_pend && ctrl_writeReg == addr)   val = data_writeReg;
    else if (ext_ack && ext_addr == addr)         val = ext_data;
    return val;
  endfunction

  always_comb begin
    data_readRegA = read_port(ctrl_readRegA);
    data_readRegB = read_port(ctrl_readRegB);
  end

  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
    assign tap_data[t*DATA_W +: DATA_W] = regs[TAP_BASE+t];
  end

endmodule
